// File: rtl/bp_me_burst_stream_arb.sv
// Purpose : shares one BedRock burst stream (header + data) among num_inputs_p producers;
//           the grant is locked from header through the last data beat, so messages never interleave.
// Latency : 1 arbitration cycle, then header and data beats forwarded combinationally from the locked input.
// Backpressure: downstream ready is steered to the locked input only; all other inputs see ready=0.
//
// Ports:
//   clk_i, reset_i                       clock, synchronous active-high reset
//   in_header_i/in_header_v_i/in_has_data_i/in_header_ready_and_o   per-input header channel (input 0 in LSBs)
//   in_data_i/in_data_v_i/in_last_i/in_data_ready_and_o             per-input data channel
//   out_header_o/out_header_v_o/out_has_data_o/out_header_ready_and_i  merged header channel
//   out_data_o/out_data_v_o/out_last_o/out_data_ready_and_i         merged data channel
//   grant_o  locked input index (debug/perf);  busy_o  high while a message is locked
//
// Build option: define BP_ME_BURST_ARB_FIXED_PRIORITY_EN for fixed priority (lowest index wins);
// the default is round-robin starting after the input that last released the lock.
// header_width_p and data_width_p default to 1 only nominally and must be set by the instantiator.

module bp_me_burst_stream_arb #(
  parameter int num_inputs_p   = 2,
  parameter int header_width_p = 1,
  parameter int data_width_p   = 1,
  localparam int lg_inputs_lp  = (num_inputs_p > 1) ? $clog2(num_inputs_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic [num_inputs_p*header_width_p-1:0] in_header_i,
  input  logic [num_inputs_p-1:0]                in_header_v_i,
  input  logic [num_inputs_p-1:0]                in_has_data_i,
  output logic [num_inputs_p-1:0]                in_header_ready_and_o,

  input  logic [num_inputs_p*data_width_p-1:0]   in_data_i,
  input  logic [num_inputs_p-1:0]                in_data_v_i,
  input  logic [num_inputs_p-1:0]                in_last_i,
  output logic [num_inputs_p-1:0]                in_data_ready_and_o,

  output logic [header_width_p-1:0]              out_header_o,
  output logic                                   out_header_v_o,
  output logic                                   out_has_data_o,
  input  logic                                   out_header_ready_and_i,

  output logic [data_width_p-1:0]                out_data_o,
  output logic                                   out_data_v_o,
  output logic                                   out_last_o,
  input  logic                                   out_data_ready_and_i,

  output logic [lg_inputs_lp-1:0]                grant_o,
  output logic                                   busy_o
);

  typedef enum logic [1:0] {e_ready, e_header, e_data} state_e;

  state_e                  state_q, state_d;
  logic [lg_inputs_lp-1:0] grant_q, grant_d;
  logic [lg_inputs_lp-1:0] rr_ptr;
  logic                    arb_v;
  logic [lg_inputs_lp-1:0] arb_idx;
  logic                    release_lock;

`ifdef BP_ME_BURST_ARB_FIXED_PRIORITY_EN
  // Search always starts at input 0, so the lowest valid index wins.
  assign rr_ptr = '0;
`else
  logic [lg_inputs_lp-1:0] rr_ptr_q, rr_ptr_d;
  logic [lg_inputs_lp-1:0] grant_inc;

  // Next search start is the input after the one releasing the lock, wrapping at num_inputs_p
  // (not at a power of two).
  assign grant_inc = (grant_q == lg_inputs_lp'(num_inputs_p - 1)) ? '0 : grant_q + 1'b1;
  assign rr_ptr_d  = release_lock ? grant_inc : rr_ptr_q;
  assign rr_ptr    = rr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Round-robin search from rr_ptr. Walking offsets from highest to lowest lets the
  // smallest offset with a valid header overwrite the others and win.
  always_comb begin
    arb_v   = 1'b0;
    arb_idx = '0;
    for (int i = num_inputs_p - 1; i >= 0; i--) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= num_inputs_p) begin
        idx = idx - num_inputs_p;
      end
      if (in_header_v_i[idx]) begin
        arb_v   = 1'b1;
        arb_idx = lg_inputs_lp'(idx);
      end
    end
  end

  // Payloads are muxed from the locked input unconditionally; only valids and readies are state gated.
  assign out_header_o   = in_header_i[int'(grant_q)*header_width_p +: header_width_p];
  assign out_has_data_o = in_has_data_i[grant_q];
  assign out_data_o     = in_data_i[int'(grant_q)*data_width_p +: data_width_p];
  assign out_last_o     = in_last_i[grant_q];
  assign grant_o        = grant_q;
  assign busy_o         = (state_q != e_ready);

  always_comb begin
    state_d               = state_q;
    grant_d               = grant_q;
    release_lock          = 1'b0;
    out_header_v_o        = 1'b0;
    out_data_v_o          = 1'b0;
    in_header_ready_and_o = '0;
    in_data_ready_and_o   = '0;

    case (state_q)
      e_ready: begin
        if (arb_v) begin
          grant_d = arb_idx;
          state_d = e_header;
        end
      end

      e_header: begin
        // A producer that drops header valid here stalls the lock; the grant is not revisited.
        out_header_v_o                 = in_header_v_i[grant_q];
        in_header_ready_and_o[grant_q] = out_header_ready_and_i;
        if (in_header_v_i[grant_q] && out_header_ready_and_i) begin
          if (in_has_data_i[grant_q]) begin
            state_d = e_data;
          end else begin
            state_d      = e_ready;
            release_lock = 1'b1;
          end
        end
      end

      e_data: begin
        // No beat count is tracked; the producer's last flag alone ends the message.
        out_data_v_o                 = in_data_v_i[grant_q];
        in_data_ready_and_o[grant_q] = out_data_ready_and_i;
        if (in_data_v_i[grant_q] && out_data_ready_and_i && in_last_i[grant_q]) begin
          state_d      = e_ready;
          release_lock = 1'b1;
        end
      end

      default: begin
        state_d = e_ready;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

endmodule

// File: tb/tb_bp_me_burst_stream_arb.sv
// Bench for bp_me_burst_stream_arb: producer models feed per-input queues, a downstream
// monitor pops per-input expectations and checks order, integrity, locking and handshakes.
// A second, 3-input instance shares inputs 0..2 to exercise non-power-of-two pointer wrap.

module tb_bp_me_burst_stream_arb;

  localparam int NI  = 4;
  localparam int NIB = 3;
  localparam int HW  = 16;
  localparam int DW  = 16;

  typedef struct {
    logic [7:0] id;
    logic       has_data;
    int         nbeats;
  } msg_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [NI*HW-1:0] in_hdr;
  logic [NI-1:0]    in_hv, in_hd, in_dv, in_last;
  logic [NI*DW-1:0] in_dat;
  logic             ohr, odr;

  logic [NI-1:0] hrdy_a, drdy_a;
  logic [HW-1:0] hdr_a;
  logic          ohv_a, hd_a, odv_a, last_a, busy_a;
  logic [DW-1:0] dat_a;
  logic [1:0]    grant_a;

  logic [NIB-1:0] hrdy_b, drdy_b;
  logic [HW-1:0]  hdr_b;
  logic           ohv_b, hd_b, odv_b, last_b, busy_b;
  logic [DW-1:0]  dat_b;
  logic [1:0]     grant_b;

  bp_me_burst_stream_arb #(.num_inputs_p(NI), .header_width_p(HW), .data_width_p(DW)) dut (
    .clk_i(clk), .reset_i(rst),
    .in_header_i(in_hdr), .in_header_v_i(in_hv), .in_has_data_i(in_hd),
    .in_header_ready_and_o(hrdy_a),
    .in_data_i(in_dat), .in_data_v_i(in_dv), .in_last_i(in_last),
    .in_data_ready_and_o(drdy_a),
    .out_header_o(hdr_a), .out_header_v_o(ohv_a), .out_has_data_o(hd_a),
    .out_header_ready_and_i(ohr),
    .out_data_o(dat_a), .out_data_v_o(odv_a), .out_last_o(last_a),
    .out_data_ready_and_i(odr),
    .grant_o(grant_a), .busy_o(busy_a)
  );

  bp_me_burst_stream_arb #(.num_inputs_p(NIB), .header_width_p(HW), .data_width_p(DW)) dut_b (
    .clk_i(clk), .reset_i(rst),
    .in_header_i(in_hdr[NIB*HW-1:0]), .in_header_v_i(in_hv[NIB-1:0]), .in_has_data_i(in_hd[NIB-1:0]),
    .in_header_ready_and_o(hrdy_b),
    .in_data_i(in_dat[NIB*DW-1:0]), .in_data_v_i(in_dv[NIB-1:0]), .in_last_i(in_last[NIB-1:0]),
    .in_data_ready_and_o(drdy_b),
    .out_header_o(hdr_b), .out_header_v_o(ohv_b), .out_has_data_o(hd_b),
    .out_header_ready_and_i(ohr),
    .out_data_o(dat_b), .out_data_v_o(odv_b), .out_last_o(last_b),
    .out_data_ready_and_i(odr),
    .grant_o(grant_b), .busy_o(busy_b)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] hdr_of(input int k, input logic [7:0] id);
    return {k[3:0], 4'h0, id};
  endfunction

  function automatic logic [15:0] dat_of(input int k, input logic [7:0] id, input int b);
    return {k[3:0], id, b[3:0]};
  endfunction

  // Stimulus and expectation queues
  msg_t msgq[NI][$];
  msg_t expq[NI][$];
  int   orderq[$];
  logic [7:0] next_id = 8'd1;
  logic [7:0] last_id;
  int   vld_pct = 100;

  task automatic push_msg(input int k, input logic has_data, input int nbeats);
    msg_t m;
    m.id = next_id;
    m.has_data = has_data;
    m.nbeats = nbeats;
    last_id = next_id;
    next_id = next_id + 8'd1;
    msgq[k].push_back(m);
    expq[k].push_back(m);
  endtask

  // Producer models
  int   p_st[NI];
  int   p_beat[NI];
  msg_t p_cur[NI];
  logic [NI-1:0] hfire, dfire;

  always @(negedge clk) begin
    hfire = in_hv & hrdy_a;
    dfire = in_dv & drdy_a;
  end

  task automatic prod_step(input int k, input logic r, input logic hf, input logic df);
    if (r) begin
      p_st[k] = 0;
      msgq[k].delete();
      expq[k].delete();
      in_hv[k] = 1'b0;
      in_dv[k] = 1'b0;
      in_last[k] = 1'b0;
    end else begin
      case (p_st[k])
        1: if (hf) begin
          in_hv[k] = 1'b0;
          if (p_cur[k].has_data) begin
            p_st[k] = 2;
            p_beat[k] = 0;
          end else begin
            p_st[k] = 0;
          end
        end
        2: if (df) begin
          in_dv[k] = 1'b0;
          p_beat[k]++;
          if (p_beat[k] == p_cur[k].nbeats) p_st[k] = 0;
        end
        default: ;
      endcase
      if (p_st[k] == 0 && msgq[k].size() > 0) begin
        p_cur[k] = msgq[k].pop_front();
        p_st[k] = 1;
        in_hdr[k*HW +: HW] = hdr_of(k, p_cur[k].id);
        in_hd[k] = p_cur[k].has_data;
        in_hv[k] = 1'b1;
      end
      if (p_st[k] == 2 && !in_dv[k]) begin
        in_dv[k] = ($urandom_range(99) < vld_pct);
        in_dat[k*DW +: DW] = dat_of(k, p_cur[k].id, p_beat[k]);
        in_last[k] = (p_beat[k] == p_cur[k].nbeats - 1);
      end
    end
  endtask

  initial begin
    logic r_s;
    logic [NI-1:0] hf_s, df_s;
    for (int k = 0; k < NI; k++) begin
      p_st[k] = 0;
      p_beat[k] = 0;
    end
    in_hdr = '0; in_hv = '0; in_hd = '0; in_dv = '0; in_last = '0; in_dat = '0;
    forever begin
      @(posedge clk);
      r_s = rst;
      hf_s = hfire;
      df_s = dfire;
      #1;
      for (int k = 0; k < NI; k++) prod_step(k, r_s, hf_s[k], df_s[k]);
    end
  end

  // Downstream monitor / scoreboard
  logic mon_in_msg = 1'b0;
  int   mon_src, mon_beat, m_src, m_n;
  msg_t mon_cur, m_e;
  int   rx_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_in_msg = 1'b0;
    end else begin
      if (ohv_a && odv_a) chk("hdr_data_same_cycle", odv_a, 0);
      if (ohv_a && ohr) begin
        m_src = int'(hdr_a[15:12]);
        chk("hdr_grant", grant_a, m_src);
        chk("hdr_overlap", mon_in_msg, 0);
        if (orderq.size() > 0) chk("order", m_src, orderq.pop_front());
        m_n = (m_src < NI) ? expq[m_src].size() : 0;
        if (m_n == 0) begin
          chk("hdr_unexpected_cnt", m_n, 1);
        end else begin
          chk("hdr_src_rdy", hrdy_a[m_src], 1);
          m_e = expq[m_src].pop_front();
          chk("hdr", hdr_a, hdr_of(m_src, m_e.id));
          chk("has_data", hd_a, m_e.has_data);
          if (m_e.has_data) begin
            mon_in_msg = 1'b1;
            mon_src = m_src;
            mon_beat = 0;
            mon_cur = m_e;
          end else begin
            rx_cnt++;
          end
        end
      end
      if (odv_a && odr) begin
        if (!mon_in_msg) begin
          chk("data_unexpected", odv_a, 0);
        end else begin
          chk("data_rdy", drdy_a[mon_src], 1);
          chk("data_grant", grant_a, mon_src);
          chk("data", dat_a, dat_of(mon_src, mon_cur.id, mon_beat));
          chk("last", last_a, (mon_beat == mon_cur.nbeats - 1));
          mon_beat++;
          if (mon_beat == mon_cur.nbeats) begin
            mon_in_msg = 1'b0;
            rx_cnt++;
          end
        end
      end
    end
  end

  function automatic bit all_idle();
    bit ok = !busy_a && !mon_in_msg;
    for (int k = 0; k < NI; k++) begin
      if (msgq[k].size() != 0 || expq[k].size() != 0 || p_st[k] != 0) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic wait_idle(input string tag, input bit rand_rdy);
    int n = 0;
    while (!all_idle() && n < 8000) begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        ohr = 1'($urandom_range(1));
        odr = 1'($urandom_range(1));
      end
      n++;
    end
    ohr = 1'b1;
    odr = 1'b1;
    chk(tag, all_idle(), 1);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, beats, b_hs;
    logic b_odv_seen, b_drdy_seen;
    logic [7:0] id0;
    int rx_start;

    rst = 1'b1;
    ohr = 1'b1;
    odr = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_hv", ohv_a, 0);
    chk("rst_dv", odv_a, 0);
    chk("rst_hrdy", hrdy_a, 0);
    chk("rst_drdy", drdy_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_grant", grant_a, 0);

    // Single requester: input 1, 4 beats, downstream always ready
    push_msg(1, 1'b1, 4);
    n = 0;
    do begin @(negedge clk); n++; end while (!in_hv[1] && n < 50);
    chk("t1_req_seen", in_hv[1], 1);
    chk("t1_arb_hv", ohv_a, 0);
    chk("t1_arb_hrdy", hrdy_a, 0);
    @(negedge clk);
    chk("t1_hdr_hv", ohv_a, 1);
    chk("t1_hdr_grant", grant_a, 1);
    chk("t1_hdr_dv", odv_a, 0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      chk("t1_beat_dv", odv_a, 1);
      chk("t1_beat_grant", grant_a, 1);
    end
    @(negedge clk);
    chk("t1_busy_done", busy_a, 0);
    chk("t1_dv_done", odv_a, 0);
    wait_idle("t1_idle", 1'b0);

    // Contention: inputs 0 and 1 each with two 2-beat messages
    @(negedge clk);
    push_msg(0, 1'b1, 2); push_msg(0, 1'b1, 2);
    push_msg(1, 1'b1, 2); push_msg(1, 1'b1, 2);
`ifdef BP_ME_BURST_ARB_FIXED_PRIORITY_EN
    orderq.push_back(0); orderq.push_back(0); orderq.push_back(1); orderq.push_back(1);
`else
    orderq.push_back(0); orderq.push_back(1); orderq.push_back(0); orderq.push_back(1);
`endif
    wait_idle("t3_idle", 1'b0);
    chk("t3_order_drained", orderq.size(), 0);

    // Lock under data backpressure while input 1 requests
    @(negedge clk);
    odr = 1'b0;
    push_msg(0, 1'b1, 3);
    id0 = last_id;
    orderq.push_back(0); orderq.push_back(1);
    n = 0;
    do begin @(negedge clk); n++; end while (!odv_a && n < 50);
    chk("t4_data_seen", odv_a, 1);
    push_msg(1, 1'b1, 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_grant", grant_a, 0);
      chk("t4_hrdy1", hrdy_a[1], 0);
      chk("t4_drdy1", drdy_a[1], 0);
      chk("t4_data_stable", dat_a, dat_of(0, id0, 0));
    end
    chk("t4_req1_waiting", in_hv[1], 1);
    odr = 1'b1;
    wait_idle("t4_idle", 1'b0);

    // Header-only from input 2, checked on the 3-input instance, then wrap check
    reset_pulse();
    @(negedge clk);
    push_msg(2, 1'b0, 0);
    orderq.push_back(2);
    b_hs = 0;
    b_odv_seen = 1'b0;
    b_drdy_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ohv_b && ohr) b_hs++;
      b_odv_seen = b_odv_seen | odv_b;
      b_drdy_seen = b_drdy_seen | (|drdy_b);
    end
    chk("t5_b_hdr_hs", b_hs, 1);
    chk("t5_b_no_dv", b_odv_seen, 0);
    chk("t5_b_no_drdy", b_drdy_seen, 0);
    chk("t5_b_busy", busy_b, 0);
    push_msg(1, 1'b1, 2);
    push_msg(2, 1'b1, 2);
    orderq.push_back(1); orderq.push_back(2);
    n = 0;
    do begin @(negedge clk); n++; end while (!ohv_b && n < 50);
    chk("t5_b_wrap_grant", grant_b, 1);
    chk("t5_b_wrap_hdr", hdr_b[15:12], 1);
    wait_idle("t5_idle", 1'b0);

    // Reset after beat 2 of 4
    @(negedge clk);
    push_msg(3, 1'b1, 4);
    n = 0;
    beats = 0;
    while (beats < 2 && n < 100) begin
      @(negedge clk);
      if (odv_a && odr) beats++;
      n++;
    end
    chk("t6_two_beats", beats, 2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_hv", ohv_a, 0);
    chk("t6_dv", odv_a, 0);
    chk("t6_hrdy", hrdy_a, 0);
    chk("t6_drdy", drdy_a, 0);
    chk("t6_grant", grant_a, 0);
    chk("t6_busy", busy_a, 0);
    push_msg(2, 1'b1, 3);
    orderq.push_back(2);
    wait_idle("t6_idle", 1'b0);

    // Random stress on all 4 inputs
    vld_pct = 60;
    rx_start = rx_cnt;
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      for (int m = 0; m < 20; m++) begin
        push_msg(k, ($urandom_range(3) != 0), int'($urandom_range(5, 1)));
      end
    end
    wait_idle("stress_drain", 1'b1);
    chk("stress_msgs", rx_cnt - rx_start, 80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
